step_ctrl: RTL

STEP_CTRL -- requirements
Module: step_ctrl

---
 rtl/step_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/step_ctrl.sv
// Single-step / free-run / burst execution controller for a CPU core.
// Gates the CPU enable from debounced button pulses and counts retired instructions.
module step_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             btn_step,
    input  logic             btn_run,
    input  logic             btn_burst,
    input  logic [15:0]      burst_len,
    input  logic             instr_done,
    input  logic             cpu_halted,
    output logic             cpu_en,
    output logic [1:0]       state,
    output logic [15:0]      burst_left,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [1:0] {
        S_HALT  = 2'd0,
        S_STEP  = 2'd1,
        S_RUN   = 2'd2,
        S_BURST = 2'd3
    } state_t;

    state_t           state_q;
    logic             cpu_en_q;
    logic             pend_step_q;
    logic             stop_req_q;
    logic [15:0]      burst_left_q;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] retired_d;

    assign retired_d  = retired_q + CNT_W'(1);

    assign cpu_en     = cpu_en_q;
    assign state      = state_q;
    assign burst_left = burst_left_q;
    assign retired    = retired_q;

    // cpu_en_q is written alongside every state_q update so it always equals (state != HALT).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= S_HALT;
            cpu_en_q     <= 1'b0;
            pend_step_q  <= 1'b0;
            stop_req_q   <= 1'b0;
            burst_left_q <= '0;
            retired_q    <= '0;
        end else begin
            if (instr_done && cpu_en_q) begin
                retired_q <= retired_d;
            end

            if (cpu_halted && (state_q != S_HALT)) begin
                state_q      <= S_HALT;
                cpu_en_q     <= 1'b0;
                pend_step_q  <= 1'b0;
                stop_req_q   <= 1'b0;
                burst_left_q <= '0;
            end else begin
                case (state_q)
                    S_HALT: begin
                        if (!cpu_halted) begin
                            if (btn_run) begin
                                state_q  <= S_RUN;
                                cpu_en_q <= 1'b1;
                            end else if (btn_burst && (burst_len != 16'd0)) begin
                                state_q      <= S_BURST;
                                cpu_en_q     <= 1'b1;
                                burst_left_q <= burst_len;
                            end else if (btn_step || pend_step_q) begin
                                state_q     <= S_STEP;
                                cpu_en_q    <= 1'b1;
                                pend_step_q <= 1'b0;
                            end
                        end
                    end

                    S_STEP: begin
                        // A step pulse arriving with the retirement is held and replayed from HALT.
                        if (instr_done) begin
                            state_q     <= S_HALT;
                            cpu_en_q    <= 1'b0;
                            pend_step_q <= pend_step_q | btn_step;
                        end else if (btn_step) begin
                            pend_step_q <= 1'b1;
                        end
                    end

                    S_RUN: begin
                        if (instr_done && (stop_req_q || btn_run)) begin
                            state_q    <= S_HALT;
                            cpu_en_q   <= 1'b0;
                            stop_req_q <= 1'b0;
                        end else if (btn_run) begin
                            stop_req_q <= 1'b1;
                        end
                    end

                    S_BURST: begin
                        if (instr_done) begin
                            if (stop_req_q || btn_run || (burst_left_q == 16'd1)) begin
                                state_q      <= S_HALT;
                                cpu_en_q     <= 1'b0;
                                stop_req_q   <= 1'b0;
                                burst_left_q <= '0;
                            end else begin
                                burst_left_q <= burst_left_q - 16'd1;
                            end
                        end else if (btn_run) begin
                            stop_req_q <= 1'b1;
                        end
                    end

                    default: begin
                        state_q  <= S_HALT;
                        cpu_en_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
